// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - in-order instruction prefetch buffer with req/gnt/rvalid memory port
module fetch_prefetch_buffer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic          r_run;
    logic [31:0]   r_inst_mem [DEPTH];
    logic [31:0]   r_pc_mem   [DEPTH];

    logic [CW:0]   w_used;
    logic          w_credit;
    logic          w_accept;
    logic          w_pop;
    logic          w_push;
    logic          w_stale;
    logic [CW-1:0] w_out_next;
    logic [31:0]   w_redirect_pc;

    // Buffered entries plus in-flight requests never exceed DEPTH, so a push always has room.
    assign w_used        = {1'b0, r_count} + {1'b0, r_out};
    assign w_credit      = w_used < (CW + 1)'(DEPTH);
    assign o_imem_req    = i_rst_n & r_run & ~i_redirect & w_credit;
    assign o_imem_addr   = r_fetch_pc;
    assign o_inst_valid  = i_rst_n & (r_count != '0);
    assign o_inst        = r_inst_mem[r_rd_ptr];
    assign o_inst_pc     = r_pc_mem[r_rd_ptr];

    assign w_accept      = o_imem_req & i_imem_gnt;
    assign w_pop         = o_inst_valid & i_inst_ready & ~i_redirect;
    assign w_stale       = r_drop != '0;
    assign w_push        = i_rst_n & i_imem_rvalid & ~i_redirect & ~w_stale;
    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};

    always_comb begin
        w_out_next = r_out;
        if (w_accept && !i_imem_rvalid) begin
            w_out_next = r_out + CW'(1);
        end else if (!w_accept && i_imem_rvalid) begin
            w_out_next = r_out - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= i_imem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_resp_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fetch_pc <= RESET_ADDR;
            r_resp_pc  <= RESET_ADDR;
            r_count    <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_run      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_out <= w_out_next;
            if (i_redirect) begin
                // Everything still in flight belongs to the old path and must be dropped.
                r_drop     <= w_out_next;
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (i_imem_rvalid && w_stale) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + AW'(1);
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb/tb_fetch_prefetch_buffer.sv - self-checking bench for fetch_prefetch_buffer
module tb_fetch_prefetch_buffer;
    localparam logic [31:0] RA    = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;

    fetch_prefetch_buffer #(.RESET_ADDR(RA), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .i_inst_ready(i_inst_ready), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct {
        logic rst_n; logic gnt; logic ready;
        logic exp_req; logic exp_valid; logic [31:0] exp_addr; logic [31:0] exp_pc;
    } vec_t;

    req_t        pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch = RA;
    int          epoch = 0;
    int          lat = 1;
    int          cyc = 0;
    int          n_accept = 0;
    int          checks = 0;
    int          errors = 0;

    logic        g_rst_n = 1'b0, g_gnt = 1'b1, g_ready = 1'b1, g_redir = 1'b0;
    logic [31:0] g_redir_pc = 32'h0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        req_t        r;
        logic [31:0] e;
        @(negedge clk);
        i_rst_n = g_rst_n; i_imem_gnt = g_gnt; i_inst_ready = g_ready;
        i_redirect = g_redir; i_redirect_pc = g_redir_pc;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            i_imem_rvalid = 1'b1; i_imem_rdata = mem_fn(pend[0].addr);
        end else begin
            i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
        end
        #1;
        s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_inst_valid;
        s_pc = o_inst_pc; s_inst = o_inst;
        if (!g_rst_n) begin
            chk("rst_req", {31'b0, s_req}, 32'd0);
            chk("rst_valid", {31'b0, s_valid}, 32'd0);
        end
        if (g_redir) chk("redir_req", {31'b0, s_req}, 32'd0);
        if (s_valid && g_ready && !g_redir && g_rst_n) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_inst actual pc=%h expected no valid entry (cycle %0d)", s_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", s_pc, e);
                chk("inst_word", s_inst, mem_fn(e));
            end
        end
        if (i_imem_rvalid) begin
            r = pend.pop_front();
            if (g_rst_n && !g_redir && r.epoch == epoch) exp_q.push_back(r.addr);
        end
        if (s_req && g_gnt) begin
            n_accept++;
            chk("fetch_addr", s_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            pend.push_back('{s_addr, epoch, cyc + lat});
        end
        if (g_redir) begin
            epoch++; exp_q.delete(); exp_fetch = {g_redir_pc[31:2], 2'b00};
        end
        if (!g_rst_n) begin
            epoch++; exp_q.delete(); pend.delete(); exp_fetch = RA;
        end
        cyc++;
        if (cyc > 5000) begin
            $display("FAIL cycle_budget actual=%0d expected<=5000", cyc);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(input int n);
        g_rst_n = 1'b0; g_redir = 1'b0;
        run(n);
        g_rst_n = 1'b1;
        cycle();
        chk("post_rst_req", {31'b0, s_req}, 32'd0);
        chk("post_rst_valid", {31'b0, s_valid}, 32'd0);
        chk("post_rst_addr", s_addr, RA);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        int k = 0;
        while (!s_valid && k < 30) begin cycle(); k++; end
        if (!s_valid) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no valid expected pc=%h", name, pc);
        end else chk(name, s_pc, pc);
    endtask

    task automatic wait_accepts(input int target);
        int k = 0;
        while (n_accept < target && k < 30) begin cycle(); k++; end
        chk("accept_wait", n_accept, target);
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RA,         32'h0};
        vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RA,         32'h0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, RA,         32'h0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, RA,         32'h0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, RA + 32'h4, 32'h0};
        vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, RA + 32'h8, RA};
        vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, RA + 32'hC, RA + 32'h4};
        vt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, RA + 32'h10, RA + 32'h8};

        // Streaming from reset at latency 1
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            g_rst_n = vt[i].rst_n; g_gnt = vt[i].gnt; g_ready = vt[i].ready;
            cycle();
            chk($sformatf("vec%0d_req", i), {31'b0, s_req}, {31'b0, vt[i].exp_req});
            chk($sformatf("vec%0d_valid", i), {31'b0, s_valid}, {31'b0, vt[i].exp_valid});
            chk($sformatf("vec%0d_addr", i), s_addr, vt[i].exp_addr);
            if (vt[i].exp_valid) chk($sformatf("vec%0d_pc", i), s_pc, vt[i].exp_pc);
        end
        run(6);

        // Backpressure: credit limit stops fetch at DEPTH, then drain in order
        do_reset(2);
        g_ready = 1'b0; n_accept = 0;
        run(12);
        chk("bp_accepts", n_accept, DEPTH);
        chk("bp_req_low", {31'b0, s_req}, 32'd0);
        chk("bp_head_pc", s_pc, RA);
        chk("bp_next_addr", s_addr, RA + 32'h10);
        g_ready = 1'b1;
        run(12);

        // Redirect with two requests in flight at latency 3
        do_reset(1);
        lat = 3; n_accept = 0;
        wait_accepts(2);
        g_redir = 1'b1; g_redir_pc = 32'h0000_2003;
        cycle();
        g_redir = 1'b0;
        cycle();
        chk("redir_next_addr", s_addr, 32'h0000_2000);
        chk("redir_next_valid", {31'b0, s_valid}, 32'd0);
        wait_valid("redir_first_pc", 32'h0000_2000);
        run(10);

        // Grant stall holds the address
        do_reset(1);
        lat = 1; n_accept = 0;
        wait_accepts(1);
        g_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_req", {31'b0, s_req}, 32'd1);
            chk("stall_addr", s_addr, RA + 32'h4);
        end
        g_gnt = 1'b1;
        run(10);

        // Redirect colliding with rvalid and a pop, then a back-to-back redirect
        lat = 2;
        run(8);
        g_redir = 1'b1; g_redir_pc = 32'h0000_3000;
        cycle();
        chk("sim_valid_during", {31'b0, s_valid}, 32'd1);
        g_redir_pc = 32'h0000_4001;
        cycle();
        g_redir = 1'b0;
        cycle();
        chk("b2b_valid_after", {31'b0, s_valid}, 32'd0);
        chk("b2b_addr", s_addr, 32'h0000_4000);
        wait_valid("b2b_first_pc", 32'h0000_4000);
        run(10);

        // Mid-run reset with a full FIFO
        lat = 1; g_ready = 1'b0;
        run(10);
        chk("full_req", {31'b0, s_req}, 32'd0);
        chk("full_valid", {31'b0, s_valid}, 32'd1);
        do_reset(1);
        g_ready = 1'b1; n_accept = 0;
        wait_accepts(1);
        wait_valid("rst_first_pc", RA);
        run(10);

        // Drain: stop granting, everything outstanding must be delivered and consumed
        g_gnt = 1'b0;
        run(20);
        chk("drain_queue", exp_q.size(), 32'd0);
        chk("drain_valid", {31'b0, s_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
